// File: rtl/toggle_cover_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cover_scheduler
// Purpose  : Collects first hits of a WIDTH-bit toggle-coverage vector into a
//            sticky bitmap. Each new hit is queued and drained one report per
//            handshake, lowest bit first, as an absolute cover index. Every
//            point is reported exactly once per clear epoch.
// Ports    : clock         - rising-edge clock
//            reset         - asynchronous active-low reset
//            valid         - per-bit toggle hits, sampled every edge
//            clear         - synchronous epoch clear (sticky + pending)
//            out_valid     - report available
//            out_ready     - consumer accepts the report
//            out_index     - COVER_INDEX + bit of the current report
//            hit_count     - distinct bits seen in the current epoch
//            pending_empty - nothing queued and no report outstanding
//            all_covered   - every bit seen in the current epoch
// Revision : 1.0 - initial release
// ============================================================================
module toggle_cover_scheduler #(
  parameter int          WIDTH       = 83,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253,
  parameter int          CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  valid,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_index,
  output logic [CNT_W-1:0]  hit_count,
  output logic              pending_empty,
  output logic              all_covered
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Configuration sanity check: the group must fit inside the cover space.
  if ((64'(COVER_INDEX) + 64'(WIDTH) > 64'(COVER_TOTAL)) || (WIDTH < 1)) begin : g_cfg_error
    $error("toggle_cover_scheduler: COVER_INDEX + WIDTH exceeds COVER_TOTAL or WIDTH < 1");
  end

  logic [WIDTH-1:0] seen;
  logic [WIDTH-1:0] pending;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] seen_next;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] load_mask;
  logic [IDX_W-1:0] low_idx;
  logic             low_found;
  logic             slot_free;
  logic             load;
  logic [CNT_W-1:0] new_cnt;
  logic [CNT_W-1:0] hit_next;
  logic [63:0]      index_next;

  // Lowest set pending bit. Scanning downward lets the last match win, which
  // is the lowest index, without needing an early exit.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx   = IDX_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // The loader works from the registered pending set only, so hits arriving
  // this cycle become reportable one cycle later. clear does not gate the
  // loader: a bit loaded in the clear cycle is still reported.
  assign slot_free = !out_valid || out_ready;
  assign load      = slot_free && low_found;
  assign load_mask = load ? (WIDTH'(1) << low_idx) : '0;

  assign base         = clear ? '0 : seen;
  assign new_hits     = valid & ~base;
  assign seen_next    = base | valid;
  assign pending_next = ((clear ? '0 : pending) & ~load_mask) | new_hits;
  assign index_next   = 64'(COVER_INDEX) + 64'(low_idx);

  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end
  end

  // hit_count never exceeds WIDTH, so CNT_W bits cannot overflow.
  assign hit_next = (clear ? '0 : hit_count) + new_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen      <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
    end else begin
      seen      <= seen_next;
      pending   <= pending_next;
      hit_count <= hit_next;
      if (slot_free) begin
        out_valid <= low_found;
        if (low_found) begin
          out_index <= index_next;
        end
      end
    end
  end

  assign pending_empty = (pending == '0) && !out_valid;
  assign all_covered   = &seen;

`ifndef SYNTHESIS
  // A stalled report must not change under the consumer.
  a_stall_stable : assert property (
    @(posedge clock) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_index))
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_toggle_cover_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_cover_scheduler
// Purpose  : Self-checking bench for toggle_cover_scheduler (WIDTH=83,
//            COVER_INDEX=100). Directed vector table, randomized traffic
//            against a reference model, full-coverage and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_cover_scheduler;

  localparam int W     = 83;
  localparam int CI    = 100;
  localparam int CNT_W = $clog2(W + 1);

  logic             clock;
  logic             reset;
  logic [W-1:0]     valid;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] hit_count;
  logic             pending_empty;
  logic             all_covered;

  toggle_cover_scheduler #(
    .WIDTH       (W),
    .COVER_INDEX (CI),
    .COVER_TOTAL (38253)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .hit_count     (hit_count),
    .pending_empty (pending_empty),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: set of seen points, set of queued points, one slot.
  logic [W-1:0] m_seen;
  logic [W-1:0] m_pend;
  logic         m_ov;
  logic [63:0]  m_idx;

  // Accept observed at the most recent edge.
  logic         acc;
  logic [63:0]  acc_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bv(input int a, input int b = -1, input int c = -1);
    logic [W-1:0] r;
    r = '0;
    if (a >= 0 && a < W) r[a[6:0]] = 1'b1;
    if (b >= 0 && b < W) r[b[6:0]] = 1'b1;
    if (c >= 0 && c < W) r[c[6:0]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_seen = '0;
    m_pend = '0;
    m_ov   = 1'b0;
    m_idx  = '0;
  endtask

  task automatic model_advance(input logic [W-1:0] v, input logic clr, input logic rdy);
    int b;
    b = -1;
    if (!m_ov || rdy) begin
      for (int i = 0; i < W; i++) if (b < 0 && m_pend[i]) b = i;
      if (b >= 0) begin
        m_ov  = 1'b1;
        m_idx = 64'(CI + b);
        m_pend[b] = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
    if (clr) begin
      m_seen = '0;
      m_pend = '0;
    end
    for (int i = 0; i < W; i++) begin
      if (v[i] && !m_seen[i]) begin
        m_seen[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  function automatic int m_hits();
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(m_seen[i]);
    return n;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".out_index"}, out_index, m_idx);
    chk({tag, ".hit_count"}, 64'(hit_count), 64'(m_hits()));
    chk({tag, ".pending_empty"}, 64'(pending_empty), 64'((m_pend == '0) && !m_ov));
    chk({tag, ".all_covered"}, 64'(all_covered), 64'(&m_seen));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic [W-1:0] v, input logic clr, input logic rdy, input string tag);
    valid     = v;
    clear     = clr;
    out_ready = rdy;
    acc       = out_valid && out_ready;
    acc_idx   = out_index;
    model_advance(v, clr, rdy);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [W-1:0] v;
    logic         clr;
    logic         rdy;
    logic         ev;
    logic [63:0]  eidx;
    int           ehit;
    logic         epe;
  } vec_t;

  vec_t tbl[23];

  function automatic logic [W-1:0] rand_hits(input int odds);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ($urandom_range(0, odds - 1) == 0);
    return r;
  endfunction

  initial begin
    int perm[W];
    bit got[W];
    int total;
    int distinct;

    // Directed sequence: expected outputs after each edge.
    tbl[0]  = '{bv(5),         1'b0, 1'b1, 1'b0, 64'd0,   1, 1'b0};
    tbl[1]  = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd105, 1, 1'b0};
    tbl[2]  = '{bv(5),         1'b0, 1'b1, 1'b0, 64'd105, 1, 1'b1};
    tbl[3]  = '{bv(-1),        1'b1, 1'b1, 1'b0, 64'd105, 0, 1'b1};
    tbl[4]  = '{bv(82, 0, 40), 1'b0, 1'b1, 1'b0, 64'd105, 3, 1'b0};
    tbl[5]  = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd100, 3, 1'b0};
    tbl[6]  = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd140, 3, 1'b0};
    tbl[7]  = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd182, 3, 1'b0};
    tbl[8]  = '{bv(-1),        1'b0, 1'b1, 1'b0, 64'd182, 3, 1'b1};
    tbl[9]  = '{bv(3, 7),      1'b1, 1'b0, 1'b0, 64'd182, 2, 1'b0};
    tbl[10] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[11] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[12] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[13] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[14] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[15] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 2, 1'b0};
    tbl[16] = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd107, 2, 1'b0};
    tbl[17] = '{bv(-1),        1'b0, 1'b1, 1'b0, 64'd107, 2, 1'b1};
    tbl[18] = '{bv(3),         1'b1, 1'b0, 1'b0, 64'd107, 1, 1'b0};
    tbl[19] = '{bv(-1),        1'b0, 1'b0, 1'b1, 64'd103, 1, 1'b0};
    tbl[20] = '{bv(3),         1'b1, 1'b0, 1'b1, 64'd103, 1, 1'b0};
    tbl[21] = '{bv(-1),        1'b0, 1'b1, 1'b1, 64'd103, 1, 1'b0};
    tbl[22] = '{bv(-1),        1'b0, 1'b1, 1'b0, 64'd103, 1, 1'b1};

    reset     = 1'b0;
    valid     = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    acc       = 1'b0;
    acc_idx   = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_index", out_index, 64'd0);
    chk("rst.hit_count", 64'(hit_count), 64'd0);
    chk("rst.pending_empty", 64'(pending_empty), 64'd1);
    chk("rst.all_covered", 64'(all_covered), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b1, "idle");

    // Directed table.
    for (int k = 0; k < 23; k++) begin
      step(tbl[k].v, tbl[k].clr, tbl[k].rdy, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.ov", k), 64'(out_valid), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d.idx", k), out_index, tbl[k].eidx);
      chk($sformatf("tbl%0d.hit", k), 64'(hit_count), 64'(tbl[k].ehit));
      chk($sformatf("tbl%0d.pe", k), 64'(pending_empty), 64'(tbl[k].epe));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(rand_hits(48), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), "rnd");
    end

    // Drain, then a fresh epoch where every point is hit exactly once-reported.
    for (int n = 0; n < 300 && !pending_empty; n++) step('0, 1'b0, 1'b1, "drain");
    chk("drain.pending_empty", 64'(pending_empty), 64'd1);
    step('0, 1'b1, 1'b1, "epoch");

    for (int i = 0; i < W; i++) begin
      perm[i] = i;
      got[i]  = 1'b0;
    end
    for (int i = W - 1; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    total    = 0;
    distinct = 0;
    for (int k = 0; k < W + 3; k += 3) begin
      logic [W-1:0] v;
      v = bv(k < W ? perm[k] : -1, k + 1 < W ? perm[k + 1] : -1, k + 2 < W ? perm[k + 2] : -1);
      if (k > 0) v = v | bv(perm[0]);
      step(v, 1'b0, ($urandom_range(0, 3) != 0), "full");
      if (acc) begin
        total++;
        if (acc_idx >= 64'(CI) && acc_idx < 64'(CI + W) && !got[int'(acc_idx) - CI]) begin
          got[int'(acc_idx) - CI] = 1'b1;
          distinct++;
        end
      end
    end
    for (int n = 0; n < 300 && !pending_empty; n++) begin
      step('0, 1'b0, 1'b1, "fulldrain");
      if (acc) begin
        total++;
        if (acc_idx >= 64'(CI) && acc_idx < 64'(CI + W) && !got[int'(acc_idx) - CI]) begin
          got[int'(acc_idx) - CI] = 1'b1;
          distinct++;
        end
      end
    end
    chk("full.total_reports", 64'(total), 64'(W));
    chk("full.distinct_reports", 64'(distinct), 64'(W));
    chk("full.all_covered", 64'(all_covered), 64'd1);
    chk("full.hit_count", 64'(hit_count), 64'(W));

    // Asynchronous reset in the middle of a stalled report.
    step(bv(10, 20), 1'b1, 1'b0, "stall0");
    step('0, 1'b0, 1'b0, "stall1");
    chk("stall.idx", out_index, 64'd110);
    step('0, 1'b0, 1'b0, "stall2");
    #3;
    reset = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.out_index", out_index, 64'd0);
    chk("arst.hit_count", 64'(hit_count), 64'd0);
    chk("arst.pending_empty", 64'(pending_empty), 64'd1);
    chk("arst.all_covered", 64'(all_covered), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    check_model("arst_hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1, "post");
    step(bv(1), 1'b0, 1'b1, "post_hit");
    step('0, 1'b0, 1'b1, "post_rep");
    chk("post.idx", out_index, 64'd101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toggle_cover_scheduler.md
Name: toggle_cover_scheduler

Overview:
- Sits between a WIDTH-bit toggle-coverage hit vector and a single coverage report channel.
- Records the first hit of each bit in a sticky bitmap and queues it as pending.
- Drains pending hits one per handshake, lowest bit first, as absolute cover indices (COVER_INDEX + bit).
- Each covered point is reported exactly once per clear epoch, so the downstream consumer (DPI sink or formal cover collector) takes one index per cycle instead of WIDTH parallel calls.

Parameters:
- WIDTH, 83, number of toggle points in this group (1..1024).
- COVER_INDEX, 0, absolute index of bit 0 within the global cover space.
- COVER_TOTAL, 38253, size of the global cover space; used only by the elaboration check.
- CNT_W, $clog2(WIDTH+1), width of hit_count.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  WIDTH  per-bit toggle hit, sampled every rising edge.
- clear  in  1  synchronous epoch clear of the sticky and pending bitmaps.
- out_valid  out  1  report available.
- out_ready  in  1  consumer accepts the report.
- out_index  out  64  absolute cover index, COVER_INDEX + bit.
- hit_count  out  CNT_W  distinct bits seen in the current epoch.
- pending_empty  out  1  no hits queued and no report outstanding.
- all_covered  out  1  every bit of the group seen in the current epoch.

Behaviour:
- Reset (reset low, asynchronous):
  - seen = 0, pending = 0.
  - out_valid = 0, out_index = 0, hit_count = 0.
  - pending_empty = 1, all_covered = 0.
  - Takes effect immediately, including mid-handshake; the in-flight report is dropped.
- Sticky bitmap and pending set:
  - base = clear ? 0 : seen.
  - new = valid & ~base.
  - seen_next = base | valid.
  - pending_next = ((clear ? 0 : pending) & ~load_mask) | new.
  - load_mask is the one-hot of the bit loaded into the output register this cycle (0 if none).
- hit_count_next = (clear ? 0 : hit_count) + popcount(new).
  - Saturation is impossible since hit_count <= WIDTH.
- Output slot: a single register.
  - free = !out_valid || out_ready.
  - When free and pending is nonzero: load the lowest set pending bit b, out_index = COVER_INDEX + b (64-bit zero-extended add), out_valid = 1, clear b from pending the same edge.
  - When free and pending is zero: out_valid = 0; out_index holds its last value.
  - While out_valid && !out_ready: out_index and out_valid hold stable.
- Throughput and latency:
  - Sustains one report per cycle while out_ready stays high.
  - Hits from the current cycle are not visible to the loader until the next cycle: minimum latency is valid sampled at edge E -> out_valid high after edge E+1.
- Simultaneous events:
  - A hit on a bit already in seen is ignored.
  - Multiple new bits in one cycle are all queued; they drain in ascending index order.
  - clear with valid in the same cycle: bits in that valid count as new in the fresh epoch.
  - clear never aborts an outstanding report; it stays until accepted.
  - The report slot may therefore carry one index from the old epoch after clear.
  - A bit loaded into the output the same cycle as clear is still reported once.
- pending_empty = (pending == 0) && !out_valid.
- all_covered = &seen (registered bitmap, no new logic).
- Elaboration check: $error if COVER_INDEX + WIDTH > COVER_TOTAL or WIDTH < 1.
- Simulation only (ifndef SYNTHESIS): assertion that out_index is stable while out_valid && !out_ready.

Test Plan:
- Reset release, valid = 0 for 10 cycles -> out_valid = 0, hit_count = 0, pending_empty = 1.
- COVER_INDEX = 100, out_ready = 1, valid[5] pulsed at edge E -> out_index = 105 with out_valid high for exactly one cycle after E+1; hit_count = 1. Re-pulsing valid[5] -> no further report.
- valid = bits {82, 0, 40} in one cycle, out_ready = 1 -> reports 100, 140, 182 on consecutive cycles; hit_count = 3.
- Backpressure: out_ready = 0 for 5 cycles with bits {3, 7} pending -> out_index stays 103; then out_ready = 1 -> 103 accepted, then 107.
- clear while out_index = 103 is stalled, with valid[3] in the same cycle -> 103 is delivered once. Because the stalled 103 was already loaded into the slot (bit 3 cleared from pending), and valid[3] in the clear cycle counts as new, bit 3 is re-queued: a second 103 follows. hit_count = 1 after clear.
- All 83 bits hit over time -> all_covered = 1 and 83 distinct reports. Asserting reset low mid-stall -> out_valid drops asynchronously and all state returns to reset values.
